// File: rtl/route_pkg.sv
// Shared types and opcode constants for the route scheduler.
package route_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_ARRIVE,
    ST_DWELL
  } state_e;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;
  localparam logic [1:0] OP_ENQ  = 2'b10;
  localparam logic [1:0] OP_CTRL = 2'b11;

  function automatic logic [7:0] stop_cmd(input logic [5:0] id);
    return {OP_GO, id};
  endfunction

endpackage

// File: rtl/route_sched_stop_fifo.sv
// Stop queue: QDEPTH x 8 circular buffer with push/pop/flush and occupancy count.
module stop_fifo #(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic [$clog2(QDEPTH):0]  count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [QDEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(QDEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign do_push = push && !flush && (!full || do_pop);
  assign drop    = push && !flush && !do_push;
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/route_sched.sv
// Route scheduler: forwards UART pass-through commands and sequences queued stops
// (issue, wait for departure, wait for arrival, dwell) to the motion controller.
//   state          | meaning
//   ST_IDLE        | waiting for a queued stop, not paused, output free
//   ST_ISSUE       | load queue head onto cmd
//   ST_WAIT_START  | waiting for cmd ack and in_transit rising
//   ST_WAIT_ARRIVE | vehicle moving; in_transit low pops the head
//   ST_DWELL       | holding at the stop for DWELL_CYCLES cycles
module route_sched
  import route_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int QDEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              ucmd,
  input  logic                    ucmd_rdy,
  output logic                    clr_ucmd_rdy,
  output logic [7:0]              cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  input  logic                    in_transit,
  output logic [$clog2(QDEPTH):0] queue_cnt,
  output logic                    queue_full,
  output logic                    dwell_active,
  output logic                    ovf
);

  localparam int DW = $clog2(DWELL_CYCLES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          paused_q, paused_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          clr_q, ovf_q;

  logic [1:0] op;
  logic       accept, pass, enq, ctrl, flush, pop;
  logic [7:0] head;
  logic       empty, drop;

  assign op     = ucmd[7:6];
  // Queue ops never touch cmd, so they bypass output back-pressure.
  assign accept = ucmd_rdy && !clr_q && (op[1] || !cmd_rdy_q);
  assign pass   = accept && !op[1];
  assign enq    = accept && (op == OP_ENQ);
  assign ctrl   = accept && (op == OP_CTRL);
  assign flush  = ctrl && !ucmd[0];

  stop_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .pop   (pop),
    .flush (flush),
    .din   (stop_cmd(ucmd[5:0])),
    .head  (head),
    .count (queue_cnt),
    .full  (queue_full),
    .empty (empty),
    .drop  (drop)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q && !clr_cmd_rdy;
    paused_d  = paused_q;
    dwell_d   = dwell_q;
    pop       = 1'b0;

    if (pass && (op == OP_STOP)) paused_d = 1'b1;
    else if (ctrl)               paused_d = 1'b0;

    if (pass || flush) begin
      state_d = ST_IDLE;
      dwell_d = '0;
      if (pass) begin
        cmd_d     = ucmd;
        cmd_rdy_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: if (!empty && !paused_q && !cmd_rdy_q) state_d = ST_ISSUE;
        ST_ISSUE: begin
          cmd_d     = head;
          cmd_rdy_d = 1'b1;
          state_d   = ST_WAIT_START;
        end
        ST_WAIT_START: if (!cmd_rdy_q && in_transit) state_d = ST_WAIT_ARRIVE;
        ST_WAIT_ARRIVE: if (!in_transit) begin
          pop     = 1'b1;
          dwell_d = '0;
          state_d = ST_DWELL;
        end
        ST_DWELL: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            state_d = ST_IDLE;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= 8'h00;
      cmd_rdy_q <= 1'b0;
      paused_q  <= 1'b0;
      dwell_q   <= '0;
      clr_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      paused_q  <= paused_d;
      dwell_q   <= dwell_d;
      clr_q     <= accept;
      ovf_q     <= drop;
    end
  end

  assign clr_ucmd_rdy = clr_q;
  assign cmd          = cmd_q;
  assign cmd_rdy      = cmd_rdy_q;
  assign ovf          = ovf_q;
  assign dwell_active = (state_q == ST_DWELL);

endmodule

// File: tb/tb_route_sched.sv
// Bench for route_sched: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against a queue-based reference model.
module tb_route_sched;

  localparam int DWC = 8;
  localparam int QD  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ucmd;
  logic       ucmd_rdy, clr_ucmd_rdy;
  logic [7:0] cmd;
  logic       cmd_rdy, clr_cmd_rdy, in_transit;
  logic [2:0] queue_cnt;
  logic       queue_full, dwell_active, ovf;

  route_sched #(.DWELL_CYCLES(DWC), .QDEPTH(QD)) dut (
    .clk          (clk),
    .rst          (rst),
    .ucmd         (ucmd),
    .ucmd_rdy     (ucmd_rdy),
    .clr_ucmd_rdy (clr_ucmd_rdy),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .in_transit   (in_transit),
    .queue_cnt    (queue_cnt),
    .queue_full   (queue_full),
    .dwell_active (dwell_active),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a stop list plus a journey phase, advanced once per clock.
  localparam int P_IDLE = 0, P_ISSUE = 1, P_DEPART = 2, P_MOVING = 3, P_HOLD = 4;
  logic [7:0] stops[$];
  int         phase, hold_left, had;
  logic [7:0] m_cmd, m_head;
  logic       m_rdy, m_ack, m_ovf, m_paused, rdy0, paused0;
  logic       acc, pass, ctrl, flush, enq;
  logic [1:0] mop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stops.delete();
      phase = P_IDLE; hold_left = 0;
      m_cmd = 8'h00; m_rdy = 0; m_ack = 0; m_ovf = 0; m_paused = 0;
    end else begin
      mop     = ucmd[7:6];
      acc     = ucmd_rdy && !m_ack && (mop[1] || !m_rdy);
      pass    = acc && !mop[1];
      ctrl    = acc && (mop == 2'b11);
      flush   = ctrl && !ucmd[0];
      enq     = acc && (mop == 2'b10);
      had     = stops.size();
      m_head  = (had > 0) ? stops[0] : 8'h00;
      rdy0    = m_rdy;
      paused0 = m_paused;
      m_ovf   = 0;
      if (flush) stops.delete();
      else begin
        if (phase == P_MOVING && !in_transit && !pass && stops.size() > 0) void'(stops.pop_front());
        if (enq) begin
          if (stops.size() < QD) stops.push_back({2'b01, ucmd[5:0]});
          else m_ovf = 1;
        end
      end
      if (pass) begin m_cmd = ucmd; m_rdy = 1; end
      else if (phase == P_ISSUE && !flush) begin m_cmd = m_head; m_rdy = 1; end
      else if (clr_cmd_rdy) m_rdy = 0;
      if (pass || flush) phase = P_IDLE;
      else if (phase == P_IDLE) begin
        if (had > 0 && !paused0 && !rdy0) phase = P_ISSUE;
      end else if (phase == P_ISSUE) phase = P_DEPART;
      else if (phase == P_DEPART) begin
        if (!rdy0 && in_transit) phase = P_MOVING;
      end else if (phase == P_MOVING) begin
        if (!in_transit) begin phase = P_HOLD; hold_left = DWC; end
      end else begin
        if (hold_left == 1) phase = P_IDLE;
        else hold_left--;
      end
      if (pass && mop == 2'b00) m_paused = 1;
      else if (ctrl) m_paused = 0;
      m_ack = acc;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cmd", cmd, m_cmd);
      chk("cmd_rdy", cmd_rdy, m_rdy);
      chk("clr_ucmd_rdy", clr_ucmd_rdy, m_ack);
      chk("ovf", ovf, m_ovf);
      chk("queue_cnt", queue_cnt, stops.size());
      chk("queue_full", queue_full, stops.size() == QD);
      chk("dwell_active", dwell_active, phase == P_HOLD);
    end
  end

  int ovf_count = 0;
  always @(negedge clk) if (!rst && ovf === 1'b1) ovf_count++;

  task automatic send(input logic [7:0] c);
    int t = 0;
    ucmd = c; ucmd_rdy = 1;
    do begin @(negedge clk); t++; end while (!clr_ucmd_rdy && t < 200);
    ucmd_rdy = 0;
    chk("ucmd_ack", clr_ucmd_rdy, 1);
  endtask

  task automatic wait_cmd();
    int t = 0;
    while (!cmd_rdy && t < 200) begin @(negedge clk); t++; end
    chk("cmd_rdy_wait", cmd_rdy, 1);
  endtask

  task automatic ack();
    clr_cmd_rdy = 1; @(negedge clk); clr_cmd_rdy = 0;
  endtask

  task automatic wait_dwell_start();
    int t = 0;
    while (!dwell_active && t < 100) begin @(negedge clk); t++; end
    chk("dwell_start", dwell_active, 1);
  endtask

  task automatic dwell_len(output int n);
    n = 0;
    while (dwell_active && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic travel(input int high);
    in_transit = 1; repeat (high) @(negedge clk); in_transit = 0;
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 99);
    logic [5:0] id = 6'($urandom_range(0, 63));
    if (r < 55) return {2'b10, id};
    if (r < 70) return 8'hC1;
    if (r < 78) return 8'hC0;
    if (r < 88) return {2'b01, id};
    return {2'b00, id};
  endfunction

  initial begin
    int n, base, hold;
    rst = 1; ucmd = 0; ucmd_rdy = 0; clr_cmd_rdy = 0; in_transit = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", cmd, 8'h00);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_queue_cnt", queue_cnt, 0);
    chk("rst_dwell", dwell_active, 0);
    chk("rst_clr_ucmd", clr_ucmd_rdy, 0);
    rst = 0; cmp_en = 1;
    @(negedge clk);

    // Two stops: issue, travel, dwell, next issue
    send(8'h85); send(8'h89);
    wait_cmd(); chk("first_issue", cmd, 8'h45); chk("cnt_two", queue_cnt, 2);
    ack(); travel(10); wait_dwell_start();
    dwell_len(n); chk("dwell_len", n, DWC);
    wait_cmd(); chk("second_issue", cmd, 8'h49); chk("cnt_after_pop", queue_cnt, 1);
    ack(); travel(3); wait_dwell_start(); dwell_len(n);
    chk("cnt_empty", queue_cnt, 0);

    // Overflow while paused
    send(8'h00); wait_cmd(); chk("stop_fwd", cmd, 8'h00); ack();
    base = ovf_count;
    for (int i = 1; i <= 4; i++) send(8'h80 + 8'(i));
    @(negedge clk);
    chk("cnt_full", queue_cnt, 4); chk("full_flag", queue_full, 1); chk("no_ovf_yet", ovf_count - base, 0);
    send(8'h85); @(negedge clk);
    chk("cnt_stays_4", queue_cnt, 4); chk("ovf_once", ovf_count - base, 1);

    // STOP mid-journey, then resume reissues the head
    send(8'hC1); wait_cmd(); chk("resume_issue", cmd, 8'h41);
    ack(); in_transit = 1; repeat (3) @(negedge clk);
    send(8'h00); wait_cmd(); chk("stop_midway", cmd, 8'h00); chk("stop_keeps_q", queue_cnt, 4);
    ack(); in_transit = 0; repeat (3) @(negedge clk);
    chk("paused_no_issue", cmd_rdy, 0);
    send(8'hC1); wait_cmd(); chk("reissue_head", cmd, 8'h41);

    // Downstream stall back-pressures a pass-through
    ucmd = 8'h00; ucmd_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_cmd", cmd, 8'h41); chk("stall_rdy", cmd_rdy, 1); chk("stall_no_ack", clr_ucmd_rdy, 0);
    end
    ack();
    n = 0;
    while (!clr_ucmd_rdy && n < 20) begin @(negedge clk); n++; end
    ucmd_rdy = 0;
    chk("stall_then_ack", clr_ucmd_rdy, 1);
    wait_cmd(); chk("stall_stop_fwd", cmd, 8'h00); ack();
    send(8'hC0); @(negedge clk); chk("flush_cnt", queue_cnt, 0);

    // Reset while dwelling with three stops queued
    send(8'h8A); send(8'h8B); send(8'h8C); send(8'h8D);
    wait_cmd(); chk("rst_case_issue", cmd, 8'h4A); ack(); travel(3);
    wait_dwell_start(); chk("dwell_cnt3", queue_cnt, 3);
    @(negedge clk);
    #2 rst = 1; #1;
    chk("arst_cnt", queue_cnt, 0); chk("arst_rdy", cmd_rdy, 0); chk("arst_dwell", dwell_active, 0);
    @(negedge clk); rst = 0; @(negedge clk);
    chk("post_rst_cnt", queue_cnt, 0);

    // Reset during an open handshake drops cmd_rdy at once
    send(8'h47); wait_cmd();
    #2 rst = 1; #1;
    chk("hs_rst_rdy", cmd_rdy, 0); chk("hs_rst_cmd", cmd, 8'h00);
    @(negedge clk); rst = 0; @(negedge clk);

    // GO wins against an issue in the same IDLE cycle
    send(8'h8A); send(8'h8B);
    wait_cmd(); ack(); travel(3); wait_dwell_start(); dwell_len(n);
    ucmd = 8'h47; ucmd_rdy = 1; @(negedge clk); ucmd_rdy = 0;
    chk("go_acked", clr_ucmd_rdy, 1); chk("go_cmd", cmd, 8'h47); chk("go_cnt", queue_cnt, 1);
    repeat (5) @(negedge clk);
    chk("go_held", cmd, 8'h47);
    ack(); wait_cmd(); chk("head_after_go", cmd, 8'h4B); ack();

    // Random traffic
    hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      clr_cmd_rdy = cmd_rdy && ($urandom_range(0, 2) == 0);
      if (hold == 0) begin in_transit = !in_transit; hold = $urandom_range(1, 12); end
      else hold--;
      if (ucmd_rdy && clr_ucmd_rdy) ucmd_rdy = 0;
      else if (!ucmd_rdy && $urandom_range(0, 3) == 0) begin ucmd = pick(); ucmd_rdy = 1; end
      if (cyc == 2000) begin
        ucmd_rdy = 0;
        #2 rst = 1; #2 rst = 0;
      end
    end
    ucmd_rdy = 0; clr_cmd_rdy = 0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
